matmul_nkm_pipe: RTL

//  Parametrised signed fixed-point matrix multiplier: RESULT(NxM) = A(NxK) x B(KxM).

---
 rtl/matmul_nkm_pipe_if.sv | 40 ++++
 rtl/matmul_nkm_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_nkm_pipe_if.sv
`default_nettype none
//==============================================================================
// Module   : matmul_nkm_pipe_if
// Purpose  : Request/response bundle for the matmul_nkm_pipe multiplier.
//            The master (requester) drives start, A and B and receives
//            busy, done, sat_flag and result. The slave is the multiplier.
// Ports    : start    - operation request
//            A        - N*K*W packed matrix A, element (0,0) in the MSBs
//            B        - K*M*W packed matrix B, element (0,0) in the MSBs
//            busy     - operation in flight
//            done     - one-cycle completion pulse
//            sat_flag - a clip event happened during the last operation
//            result   - N*M*W packed result, element (0,0) in the MSBs
// Revision : 1.0 - initial release
//==============================================================================
interface matmul_nkm_pipe_if #(
  parameter int W = 16,
  parameter int N = 4,
  parameter int K = 4,
  parameter int M = 2
);
  logic             start;
  logic [N*K*W-1:0] A;
  logic [K*M*W-1:0] B;
  logic             busy;
  logic             done;
  logic             sat_flag;
  logic [N*M*W-1:0] result;

  modport master (
    output start, A, B,
    input  busy, done, sat_flag, result
  );

  modport slave (
    input  start, A, B,
    output busy, done, sat_flag, result
  );
endinterface
`default_nettype wire

// File: rtl/matmul_nkm_pipe.sv
`default_nettype none
//==============================================================================
// Module   : matmul_nkm_pipe
// Purpose  : Signed fixed-point matrix multiplier RESULT(NxM) = A(NxK) x B(KxM),
//            Q(W-FRAC).FRAC elements. Row-serial, two pipeline stages
//            (multiply, add), start/busy/done handshake. A and B are latched
//            when start is accepted; result is presented atomically with done.
// Ports    : clk     - clock, rising edge
//            reset_n - asynchronous active-low reset
//            mm      - matmul_nkm_pipe_if.slave (start, A, B, busy, done,
//                      sat_flag, result)
// Config   : MATMUL_SAT_EN defined   -> products and sums saturate, sat_flag
//                                       reports any clip in the operation.
//            MATMUL_SAT_EN undefined -> products and sums wrap to W bits,
//                                       sat_flag stays 0.
// Revision : 1.0 - initial release
//==============================================================================
module matmul_nkm_pipe #(
  parameter int W    = 16,
  parameter int FRAC = 8,
  parameter int N    = 4,
  parameter int K    = 4,
  parameter int M    = 2
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  matmul_nkm_pipe_if.slave mm
);

  localparam int c_PW = 2 * W;                    // full product width
  localparam int c_SW = W + $clog2(K);            // growth-safe sum width
  localparam int c_RW = (N > 1) ? $clog2(N) : 1;  // row index width
  localparam logic [c_RW-1:0] c_LAST_ROW = c_RW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Reduce a shifted product to W bits; bit W carries the clip event.
  function automatic logic [W:0] clip_p(input logic [c_PW-1:0] v);
`ifdef MATMUL_SAT_EN
    logic [c_PW-W:0] hi;
    hi = v[c_PW-1:W-1];
    // In range when every bit from the W-1 position up matches the sign.
    if ((&hi) || (~|hi)) clip_p = {1'b0, v[W-1:0]};
    else                 clip_p = {1'b1, v[c_PW-1], {(W-1){~v[c_PW-1]}}};
`else
    clip_p = {1'b0, v[W-1:0]};
`endif
  endfunction

  // Same reduction for the widened row sum.
  function automatic logic [W:0] clip_s(input logic [c_SW-1:0] v);
`ifdef MATMUL_SAT_EN
    logic [c_SW-W:0] hi;
    hi = v[c_SW-1:W-1];
    if ((&hi) || (~|hi)) clip_s = {1'b0, v[W-1:0]};
    else                 clip_s = {1'b1, v[c_SW-1], {(W-1){~v[c_SW-1]}}};
`else
    clip_s = {1'b0, v[W-1:0]};
`endif
  endfunction

  // Control
  state_t          r_state, w_state_nxt;
  logic [c_RW-1:0] r_row, w_row_nxt;
  logic            w_accept, w_issue, w_finish;

  // Latched operands and their element views
  logic [N*K*W-1:0]    r_a;
  logic [K*M*W-1:0]    r_b;
  logic signed [W-1:0] w_a [N][K];
  logic signed [W-1:0] w_b [K][M];

  // Multiply stage
  logic signed [W-1:0] w_prod [M][K];
  logic                w_pclip;
  logic                r_p_vld;
  logic [c_RW-1:0]     r_p_row;
  logic signed [W-1:0] r_prod [M][K];
  logic                r_p_clip;

  // Add stage, shadow buffer and outputs
  logic [W-1:0]     w_sum [M];
  logic             w_sclip;
  logic [W-1:0]     r_shadow [N][M];
  logic             r_sat_acc;
  logic             r_done;
  logic             r_sat_flag;
  logic [N*M*W-1:0] r_result;

  for (genvar gi = 0; gi < N; gi++) begin : g_a_row
    for (genvar gk = 0; gk < K; gk++) begin : g_a_col
      assign w_a[gi][gk] = r_a[(N*K-1-(gi*K+gk))*W +: W];
    end
  end

  for (genvar gk = 0; gk < K; gk++) begin : g_b_row
    for (genvar gj = 0; gj < M; gj++) begin : g_b_col
      assign w_b[gk][gj] = r_b[(K*M-1-(gk*M+gj))*W +: W];
    end
  end

  //----------------------------------------------------------------------------
  // FSM: one RUN cycle per row, then one DRAIN cycle while the last row's
  // sum is formed. The finishing edge loads result/done and returns to IDLE,
  // so the FSM is IDLE during the done cycle and a start there is taken on
  // the very next edge (one op every N+2 edges).
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mm.start) begin
          w_accept    = 1'b1;
          w_row_nxt   = '0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_issue = 1'b1;
        if (r_row == c_LAST_ROW) w_state_nxt = S_DRAIN;
        else                     w_row_nxt   = r_row + 1'b1;
      end
      S_DRAIN: begin
        w_finish    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  //----------------------------------------------------------------------------
  // Multiply stage: all M*K products of the issued row, arithmetic shift
  // (floor) by FRAC, then reduced to W bits.
  //----------------------------------------------------------------------------
  always_comb begin
    logic signed [c_PW-1:0] w_full;
    logic signed [c_PW-1:0] w_shift;
    logic [W:0]             w_cv;
    w_pclip = 1'b0;
    w_full  = '0;
    w_shift = '0;
    w_cv    = '0;
    for (int j = 0; j < M; j++) begin
      for (int k = 0; k < K; k++) begin
        w_full       = c_PW'(w_a[r_row][k]) * c_PW'(w_b[k][j]);
        w_shift      = w_full >>> FRAC;
        w_cv         = clip_p(w_shift);
        w_prod[j][k] = w_cv[W-1:0];
        w_pclip      = w_pclip | w_cv[W];
      end
    end
  end

  //----------------------------------------------------------------------------
  // Add stage: sign-extend the K clipped products into c_SW bits so the sum
  // itself cannot overflow, then reduce to W. With K=1 this is a pass-through.
  //----------------------------------------------------------------------------
  always_comb begin
    logic signed [c_SW-1:0] w_acc;
    logic [W:0]             w_sv;
    w_sclip = 1'b0;
    w_acc   = '0;
    w_sv    = '0;
    for (int j = 0; j < M; j++) begin
      w_acc = '0;
      for (int k = 0; k < K; k++) begin
        w_acc = w_acc + c_SW'(r_prod[j][k]);
      end
      w_sv     = clip_s(w_acc);
      w_sum[j] = w_sv[W-1:0];
      w_sclip  = w_sclip | w_sv[W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_p_vld    <= 1'b0;
      r_p_row    <= '0;
      r_p_clip   <= 1'b0;
      r_sat_acc  <= 1'b0;
      r_done     <= 1'b0;
      r_sat_flag <= 1'b0;
      r_result   <= '0;
      for (int j = 0; j < M; j++) begin
        for (int k = 0; k < K; k++) r_prod[j][k] <= '0;
      end
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < M; j++) r_shadow[i][j] <= '0;
      end
    end else begin
      r_p_vld <= w_issue;
      r_done  <= w_finish;

      if (w_accept) begin
        r_a <= mm.A;
        r_b <= mm.B;
      end

      if (w_issue) begin
        r_p_row  <= r_row;
        r_p_clip <= w_pclip;
        for (int j = 0; j < M; j++) begin
          for (int k = 0; k < K; k++) r_prod[j][k] <= w_prod[j][k];
        end
      end

      if (r_p_vld) begin
        for (int j = 0; j < M; j++) r_shadow[r_p_row][j] <= w_sum[j];
      end

      if (w_accept)     r_sat_acc <= 1'b0;
      else if (r_p_vld) r_sat_acc <= r_sat_acc | r_p_clip | w_sclip;

      // The last row is still in the add stage on the finishing edge, so it
      // bypasses the shadow buffer straight into result.
      if (w_finish) begin
        r_sat_flag <= r_sat_acc | r_p_clip | w_sclip;
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < M; j++) begin
            if (i == N - 1) r_result[(N*M-1-(i*M+j))*W +: W] <= w_sum[j];
            else            r_result[(N*M-1-(i*M+j))*W +: W] <= r_shadow[i][j];
          end
        end
      end
    end
  end

  assign mm.busy     = (r_state != S_IDLE);
  assign mm.done     = r_done;
  assign mm.sat_flag = r_sat_flag;
  assign mm.result   = r_result;

endmodule
`default_nettype wire
